arc4_encrypt: RTL

ARC4_ENCRYPT -- requirements
Module: arc4_encrypt

---
 rtl/arc4_encrypt_if.sv | 24 ++
 rtl/arc4_encrypt.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/arc4_encrypt_if.sv
// Request/memory bundle for the ARC4 encryptor: handshake, key, plaintext
// read port, ciphertext write port and the sticky charset error flag.
interface arc4_encrypt_if;
    logic        valid;
    logic        ready;
    logic [23:0] key;
    logic [7:0]  pt_addr;
    logic [7:0]  pt_rddata;
    logic [7:0]  ct_addr;
    logic [7:0]  ct_wrdata;
    logic        ct_wren;
    logic        err;

    // Requester side (also hosts the plaintext/ciphertext memories).
    modport master (
        output valid, key, pt_rddata,
        input  ready, pt_addr, ct_addr, ct_wrdata, ct_wren, err
    );

    modport slave (
        input  valid, key, pt_rddata,
        output ready, pt_addr, ct_addr, ct_wrdata, ct_wren, err
    );
endinterface

// File: rtl/arc4_encrypt.sv
// ARC4 stream encryptor: builds the S-box from a 24-bit key, then XORs each
// length-prefixed plaintext byte with the keystream into ciphertext memory.
module arc4_encrypt (
    input  logic          clk,
    input  logic          rst_n,
    arc4_encrypt_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, INIT_S, KSA, READ_LEN, PRGA, DONE
    } state_t;

    state_t      state, next_state;
    logic [2:0]  phase;
    logic [7:0]  i, j, k, len;
    logic [7:0]  si, sj, ptb;
    logic [1:0]  k3;
    logic [23:0] key_q;
    logic        err_q;

    // S-box: one synchronous read port, one write port
    logic [7:0]  s_mem [256];
    logic [7:0]  s_rdata, s_raddr, s_waddr, s_wdata;
    logic        s_we;

    logic [7:0]  key_byte, j_sum;

    function automatic logic in_charset(input logic [7:0] b);
        return ((b >= 8'd97) && (b <= 8'd122)) || (b == 8'd32);
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case statements leaves a value held (no inferred latch).
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:     if (bus.valid) next_state = INIT_S;
            INIT_S:   if (i == 8'd255) next_state = KSA;
            KSA:      if (phase == 3'd3 && i == 8'd255) next_state = READ_LEN;
            READ_LEN: if (phase == 3'd1)
                          next_state = (bus.pt_rddata == 8'd0) ? DONE : PRGA;
            PRGA:     if (phase == 3'd4 && k == len) next_state = DONE;
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        key_byte = key_q[7:0];
        case (k3)
            2'd0:    key_byte = key_q[23:16];
            2'd1:    key_byte = key_q[15:8];
            default: key_byte = key_q[7:0];
        endcase
        j_sum = j + s_rdata + ((state == KSA) ? key_byte : 8'd0);
    end

    // Outputs and S-box port controls, sequenced by state and phase.
    always_comb begin
        bus.ready     = 1'b0;
        bus.pt_addr   = 8'd0;
        bus.ct_addr   = 8'd0;
        bus.ct_wrdata = 8'd0;
        bus.ct_wren   = 1'b0;
        s_raddr       = i;
        s_we          = 1'b0;
        s_waddr       = i;
        s_wdata       = 8'd0;
        unique case (state)
            IDLE: bus.ready = 1'b1;
            INIT_S: begin
                s_we    = 1'b1;
                s_wdata = i;
            end
            KSA: begin
                case (phase)
                    3'd1: s_raddr = j_sum;
                    3'd2: begin
                        s_we    = 1'b1;
                        s_wdata = s_rdata;
                    end
                    3'd3: begin
                        s_we    = 1'b1;
                        s_waddr = j;
                        s_wdata = si;
                    end
                    default: s_raddr = i;
                endcase
            end
            READ_LEN: begin
                if (phase == 3'd1) begin
                    bus.ct_wren   = 1'b1;
                    bus.ct_wrdata = bus.pt_rddata;
                end
            end
            PRGA: begin
                bus.pt_addr = k;
                case (phase)
                    3'd0: s_raddr = i + 8'd1;
                    3'd1: s_raddr = j_sum;
                    3'd2: begin
                        s_we    = 1'b1;
                        s_wdata = s_rdata;
                    end
                    3'd3: begin
                        // Pad read overlaps the S[j] write; the write-first
                        // port returns the swapped value when they collide.
                        s_we    = 1'b1;
                        s_waddr = j;
                        s_wdata = si;
                        s_raddr = si + sj;
                    end
                    3'd4: begin
                        bus.ct_wren   = 1'b1;
                        bus.ct_addr   = k;
                        bus.ct_wrdata = ptb ^ s_rdata;
                    end
                    default: s_raddr = i;
                endcase
            end
            DONE: bus.ready = 1'b0;
            default: bus.ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 3'd0;
            i     <= 8'd0;
            j     <= 8'd0;
            k     <= 8'd0;
            len   <= 8'd0;
            si    <= 8'd0;
            sj    <= 8'd0;
            ptb   <= 8'd0;
            k3    <= 2'd0;
            key_q <= 24'd0;
            err_q <= 1'b0;
        end else begin
            phase <= phase + 3'd1;
            unique case (state)
                IDLE: begin
                    phase <= 3'd0;
                    if (bus.valid) begin
                        key_q <= bus.key;
                        err_q <= 1'b0;
                        i     <= 8'd0;
                        j     <= 8'd0;
                        k3    <= 2'd0;
                    end
                end
                INIT_S: begin
                    phase <= 3'd0;
                    i     <= i + 8'd1;
                end
                KSA: begin
                    case (phase)
                        3'd1: begin
                            si <= s_rdata;
                            j  <= j_sum;
                        end
                        3'd3: begin
                            phase <= 3'd0;
                            i     <= i + 8'd1;
                            k3    <= (k3 == 2'd2) ? 2'd0 : k3 + 2'd1;
                        end
                        default: ;
                    endcase
                end
                READ_LEN: begin
                    if (phase == 3'd1) begin
                        phase <= 3'd0;
                        len   <= bus.pt_rddata;
                        i     <= 8'd0;
                        j     <= 8'd0;
                        k     <= 8'd1;
                    end
                end
                PRGA: begin
                    case (phase)
                        3'd0: i <= i + 8'd1;
                        3'd1: begin
                            si  <= s_rdata;
                            j   <= j_sum;
                            ptb <= bus.pt_rddata;
                        end
                        3'd2: sj <= s_rdata;
                        3'd4: begin
                            phase <= 3'd0;
                            k     <= k + 8'd1;
                            if (!in_charset(ptb)) err_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                DONE:    phase <= 3'd0;
                default: phase <= 3'd0;
            endcase
        end
    end

    // NOTE: the S-box array has no reset; INIT_S rewrites every entry before
    // it is read, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (s_we) s_mem[s_waddr] <= s_wdata;
        s_rdata <= (s_we && (s_waddr == s_raddr)) ? s_wdata : s_mem[s_raddr];
    end

    assign bus.err = err_q;

endmodule
